// File: rtl/wbu_pipeline_if.sv
// Commit bus from the memory stage into the write-back unit.
// The master drives the payload and in_valid; the slave answers with in_ready.
interface wbu_pipeline_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [31:0] in_result;
  logic [31:0] in_csr_wdata;
  logic [31:0] in_a0_data;
  logic [4:0]  in_rd;
  logic        in_reg_wen;
  logic        in_csr_wen;
  logic        in_ebreak;
  logic        in_ecall;
  logic        in_mret;
  logic [11:0] in_csr_addr;

  modport master (
    output in_valid, in_pc, in_inst, in_result, in_csr_wdata, in_a0_data, in_rd,
           in_reg_wen, in_csr_wen, in_ebreak, in_ecall, in_mret, in_csr_addr,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_result, in_csr_wdata, in_a0_data, in_rd,
           in_reg_wen, in_csr_wen, in_ebreak, in_ecall, in_mret, in_csr_addr,
    output in_ready
  );
endinterface

// File: rtl/wbu_pipeline.sv
// Write-back unit: retires committed instructions, owns the machine CSRs,
// and raises flush/redirect on ecall/mret and halt on ebreak.
module wbu_pipeline (
  input  logic          clk,
  input  logic          rst_n,
  wbu_pipeline_if.slave cmt,
  output logic          rf_wen,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  input  logic [11:0]   csr_raddr,
  output logic [31:0]   csr_rdata,
  output logic          flush,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc,
  output logic          halt,
  output logic [31:0]   halt_code,
  output logic          commit_valid,
  output logic [31:0]   commit_pc,
  output logic [63:0]   instret
);

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMtvec   = 12'h305;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;

  typedef enum logic [1:0] {StRun, StRedirect, StHalt} state_e;

  state_e      state_q, state_d;
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [31:0] redirect_pc_q, redirect_pc_d, halt_code_q, halt_code_d;
  logic        rf_wen_q, commit_valid_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q, commit_pc_q;
  logic [63:0] instret_q;
  logic        commit;
  logic [31:0] mstatus;
  logic        unused_inst;

  // Only MIE/MPIE are writable; MPP is hardwired to machine mode.
  function automatic logic [31:0] csr_mask(logic [11:0] addr, logic [31:0] data);
    case (addr)
      AddrMstatus:                     csr_mask = (data & 32'h0000_0088) | 32'h0000_1800;
      AddrMtvec, AddrMepc, AddrMcause: csr_mask = data;
      default:                         csr_mask = 32'h0;
    endcase
  endfunction

  assign unused_inst = ^cmt.in_inst;
  assign cmt.in_ready = (state_q == StRun);
  assign commit       = cmt.in_valid && cmt.in_ready;
  assign mstatus      = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

  always_comb begin
    csr_rdata = 32'h0;
    if (commit && cmt.in_csr_wen && (cmt.in_csr_addr == csr_raddr)) begin
      csr_rdata = csr_mask(csr_raddr, cmt.in_csr_wdata);
    end else begin
      case (csr_raddr)
        AddrMstatus: csr_rdata = mstatus;
        AddrMtvec:   csr_rdata = mtvec_q;
        AddrMepc:    csr_rdata = mepc_q;
        AddrMcause:  csr_rdata = mcause_q;
        default:     csr_rdata = 32'h0;
      endcase
    end
  end

  // CSR write is applied first so a trap in the same commit sees post-write values.
  always_comb begin
    state_d       = state_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    redirect_pc_d = redirect_pc_q;
    halt_code_d   = halt_code_q;
    if (state_q == StRedirect) state_d = StRun;
    if (commit && cmt.in_csr_wen) begin
      case (cmt.in_csr_addr)
        AddrMstatus: begin
          mie_d  = cmt.in_csr_wdata[3];
          mpie_d = cmt.in_csr_wdata[7];
        end
        AddrMtvec:  mtvec_d  = cmt.in_csr_wdata;
        AddrMepc:   mepc_d   = cmt.in_csr_wdata;
        AddrMcause: mcause_d = cmt.in_csr_wdata;
        default: ;
      endcase
    end
    if (commit) begin
      if (cmt.in_ebreak) begin
        halt_code_d = cmt.in_a0_data;
        state_d     = StHalt;
      end else if (cmt.in_ecall) begin
        mepc_d        = cmt.in_pc;
        mcause_d      = 32'd11;
        mpie_d        = mie_d;
        mie_d         = 1'b0;
        redirect_pc_d = {mtvec_d[31:2], 2'b00};
        state_d       = StRedirect;
      end else if (cmt.in_mret) begin
        mie_d         = mpie_d;
        mpie_d        = 1'b1;
        redirect_pc_d = mepc_d;
        state_d       = StRedirect;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      mie_q          <= 1'b0;
      mpie_q         <= 1'b0;
      mtvec_q        <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      redirect_pc_q  <= 32'h0;
      halt_code_q    <= 32'h0;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= 5'd0;
      rf_wdata_q     <= 32'h0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= 32'h0;
      instret_q      <= 64'd0;
    end else begin
      state_q        <= state_d;
      mie_q          <= mie_d;
      mpie_q         <= mpie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      redirect_pc_q  <= redirect_pc_d;
      halt_code_q    <= halt_code_d;
      rf_wen_q       <= commit && cmt.in_reg_wen && (cmt.in_rd != 5'd0);
      commit_valid_q <= commit;
      if (commit) begin
        rf_waddr_q  <= cmt.in_rd;
        rf_wdata_q  <= cmt.in_result;
        commit_pc_q <= cmt.in_pc;
        instret_q   <= instret_q + 64'd1;
      end
    end
  end

  assign rf_wen         = rf_wen_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign flush          = (state_q == StRedirect);
  assign redirect_valid = (state_q == StRedirect);
  assign redirect_pc    = redirect_pc_q;
  assign halt           = (state_q == StHalt);
  assign halt_code      = halt_code_q;
  assign commit_valid   = commit_valid_q;
  assign commit_pc      = commit_pc_q;
  assign instret        = instret_q;

endmodule
